rr_mux4_arbiter: RTL

Round-robin arbiter and select sequencer for the 4:1 mux datapath (in0..in3 -> out).
- Shares the single mux output between four requesters.
- Grants one requester at a time for a bounded burst.
- Drives the mux select pins sel1/sel0 from registers so the select never glitches.
- Sits between requesting sources and the shared 4:1 mux. A valid flag qualifies the mux output for downstream logic.

---
 rtl/rr_mux4_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving registered select lines of a shared 4:1 mux.
// Ports: clk, rst, req[3:0], done[3:0] -> gnt[3:0], sel1, sel0, valid, ptr[1:0].
module rr_mux4_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic       sel1,
  output logic       sel0,
  output logic       valid,
  output logic [1:0] ptr
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  state_t        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    sel_q;
  logic          valid_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;

  logic [1:0] own;
  logic [1:0] arb_ptr_d;
  logic       hit_d;
  logic [1:0] win_d;
  logic       rel_d;

  // First set bit of r, scanning from index p upward with wrap.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign own = sel_q;

  always_comb begin
    arb_ptr_d = ptr_q;
    // On release the owner drops to lowest priority for the re-scan.
    if (state_q == GRANT) arb_ptr_d = own + 2'd1;
    {hit_d, win_d} = pick(req, arb_ptr_d);
    rel_d = !req[own] || done[own] || (cnt_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit_d) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << win_d;
            sel_q   <= win_d;
            valid_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (!rel_d) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            ptr_q <= own + 2'd1;
            cnt_q <= '0;
            if (hit_d) begin
              gnt_q <= 4'b0001 << win_d;
              sel_q <= win_d;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign sel1  = sel_q[1];
  assign sel0  = sel_q[0];
  assign valid = valid_q;
  assign ptr   = ptr_q;

endmodule
